// File: rtl/shift_restore_low_pkg.sv
// Shared constants for the calc_int shift path: FSM encoding, default widths
// and the count clamp used by both the normaliser and the restorer.
package shift_restore_low_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } srl_state_e;

    // Counts at or beyond the data width all mean "shift everything out".
    function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned lim);
        return (cnt >= lim) ? lim : cnt;
    endfunction

endpackage

// File: rtl/shift_restore_low_if.sv
// start/busy/done handshake between the calc_int sequencer (master) and the
// iterative left shifter (slave).
interface shift_restore_low_if
    import shift_restore_low_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [CNT_W-1:0] n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    modport master (output start, a, n, input busy, done, result, ovf);
    modport slave  (input start, a, n, output busy, done, result, ovf);
endinterface

// File: rtl/shift_restore_low.sv
// Iterative left shifter: undoes the right-shift normalisation one bit per
// clock and flags any set bit pushed out of the MSB.
module shift_restore_low
    import shift_restore_low_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_restore_low_if.slave  bus
);
    // Must hold the value WIDTH itself, so one more bit than log2(WIDTH).
    localparam int REM_W = $clog2(WIDTH + 1);

    srl_state_e       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [REM_W-1:0] n_sat;

    assign n_sat = REM_W'(clamp_cnt(32'(bus.n), WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // done is registered: it is raised on the edge that enters DONE.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    res_d  = bus.a;
                    ovf_d  = 1'b0;
                    rem_d  = n_sat;
                    busy_d = 1'b1;
                    if (n_sat == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                res_d = {res_q[WIDTH-2:0], 1'b0};
                ovf_d = ovf_q | res_q[WIDTH-1];
                rem_d = rem_q - 1'b1;
                if (rem_q == REM_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_shift_restore_low.sv
// Randomised + directed bench for shift_restore_low against a shift-count
// model of the operation.
module tb_shift_restore_low;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    shift_restore_low_if bus ();
    shift_restore_low dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Model: the operand, how many shifts have been applied, edges left.
    logic [31:0] m_a = '0;
    int          m_sh = 0;
    int          m_left = 0;
    bit          m_busy = 0;
    bit          m_done = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = '0; m_sh = 0; m_left = 0; m_busy = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_sh++; m_left--;
            if (m_left == 0) m_done = 1;
        end else if (bus.start) begin
            m_a    = bus.a;
            m_sh   = 0;
            m_left = (bus.n >= 6'd32) ? 32 : int'(bus.n);
            m_busy = 1;
            m_done = (m_left == 0);
        end
    end

    always @(negedge clk) begin
        logic [63:0] full;
        if (rst_n) begin
            full = {32'h0, m_a} << m_sh;
            chk("busy", 64'(bus.busy), 64'(m_busy));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("result", 64'(bus.result), {32'h0, full[31:0]});
            chk("ovf", 64'(bus.ovf), 64'(|full[63:32]));
        end
    end

    task automatic run_op(input logic [31:0] av, input logic [5:0] nv, input bit pin,
                          input logic [31:0] er, input logic er_ovf, input bit glitch,
                          input string tag);
        int lat, bcnt, k;
        k = (nv >= 6'd32) ? 32 : int'(nv);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.n = nv;
        @(negedge clk);
        bus.start = 1'b0; bus.a = $urandom; bus.n = 6'($urandom);
        lat = 1; bcnt = 0;
        forever begin
            if (bus.busy) bcnt++;
            if (bus.done || lat >= 80) break;
            @(negedge clk);
            lat++;
            if (glitch && lat == 3) begin
                bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.n = 6'd2;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(k + 1));
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(k + 1));
        if (pin) begin
            chk({tag, "_result"}, 64'(bus.result), 64'(er));
            chk({tag, "_ovf"}, 64'(bus.ovf), 64'(er_ovf));
        end
        @(negedge clk);
        chk({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int dpos[$];
        bus.start = 1'b0; bus.a = '0; bus.n = '0;
        #7;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_ovf", 64'(bus.ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0000_0001, 6'd4,  1, 32'h0000_0010, 1'b0, 0, "basic");
        run_op(32'hDEAD_BEEF, 6'd0,  1, 32'hDEAD_BEEF, 1'b0, 0, "zero");
        run_op(32'hC000_0001, 6'd1,  1, 32'h8000_0002, 1'b1, 0, "ovf1");
        run_op(32'h4000_0000, 6'd2,  1, 32'h0000_0000, 1'b1, 0, "ovf2");
        run_op(32'h0000_0001, 6'd40, 1, 32'h0000_0000, 1'b1, 0, "sat1");
        run_op(32'h0000_0000, 6'd63, 1, 32'h0000_0000, 1'b0, 0, "sat0");
        run_op(32'h0000_0001, 6'd10, 1, 32'h0000_0400, 1'b0, 1, "ignore");

        // Start held high: one IDLE cycle between operations, so period n+2.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h3; bus.n = 6'd2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) dpos.push_back(i);
        end
        bus.start = 1'b0;
        chk("b2b_pulses", 64'(dpos.size() >= 4), 64'd1);
        for (int i = 1; i < dpos.size(); i++)
            chk("b2b_gap", 64'(dpos[i] - dpos[i-1]), 64'd4);
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-shift.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.n = 6'd20;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_result", 64'(bus.result), 64'd0);
        chk("arst_ovf", 64'(bus.ovf), 64'd0);
        repeat (2) @(negedge clk);
        chk("arst_hold_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        run_op(32'h0000_000F, 6'd8, 1, 32'h0000_0F00, 1'b0, 0, "post_rst");

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op($urandom, 6'($urandom), 0, 32'h0, 1'b0, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
